glyph_scan_ctrl: RTL and testbench

GLYPH_SCAN_CTRL -- requirements
Module: glyph_scan_ctrl

---
 rtl/glyph_scan_ctrl.sv | 118 +++++++++++
 tb/tb_glyph_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/glyph_scan_ctrl.sv
// glyph_scan_ctrl: walks a ROWS x COLS window of 8x8 text cells in step with
// the VGA pixel stream. It selects the glyph ROM row/cell and serialises the
// 5-pixel glyph row onto pixel_on with zero pixel latency.
// Optional feature macro: GLYPH_HILITE_EN. When it is defined, the cell at
// {hl_row, hl_col} is drawn inverted while hl_on is high.
module glyph_scan_ctrl #(
  parameter logic [9:0] X0   = 10'd200,
  parameter logic [9:0] Y0   = 10'd160,
  parameter int         COLS = 4,
  parameter int         ROWS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [4:0] glyph_code,
`ifdef GLYPH_HILITE_EN
  input  logic [2:0] hl_col,
  input  logic [1:0] hl_row,
  input  logic       hl_on,
`endif
  output logic [2:0] rom_row,
  output logic [4:0] glyph_sel,
  output logic       pixel_on,
  output logic       line_done
);

  // The glyph is loaded one pixel early, so its first bit is on screen at X0.
  localparam logic [9:0]  X_START  = X0 - 10'd1;
  localparam logic [10:0] Y_END    = {1'b0, Y0} + 11'(8 * ROWS);
  localparam logic [2:0]  LAST_COL = 3'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t     state;
  logic [4:0] shreg;
  logic [2:0] col;
  logic [2:0] cnt;

  logic [4:0] ypos;
  logic       in_win_y;
  logic [1:0] cell_row;
  logic [2:0] next_col;
  logic       base_on;

  // Window decode and ROM addressing; the ROM answers within the same pixel.
  always_comb begin
    ypos      = pixel_y[4:0] - Y0[4:0];
    in_win_y  = (pixel_y >= Y0) && ({1'b0, pixel_y} < Y_END);
    rom_row   = ypos[2:0];
    cell_row  = ypos[4:3];
    next_col  = (state == IDLE) ? 3'd0 : col + 3'd1;
    glyph_sel = {cell_row, next_col};
  end

  // Foreground output taken straight from the shifter MSB, gated by video_on.
  always_comb begin
    base_on = (state == SHIFT) && shreg[4];
`ifdef GLYPH_HILITE_EN
    if (hl_on && (state != IDLE) && ({cell_row, col} == {hl_row, hl_col})) begin
      base_on = ~base_on;
    end
`endif
    pixel_on = base_on && video_on;
  end

  // Cell sequencer: 5 shift pixels, 3 gap pixels, next glyph loaded on the last gap pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= 5'd0;
      col       <= 3'd0;
      cnt       <= 3'd0;
      line_done <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (pix_tick) begin
        case (state)
          IDLE: begin
            if ((pixel_x == X_START) && in_win_y) begin
              shreg <= glyph_code;
              col   <= 3'd0;
              cnt   <= 3'd0;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            shreg <= shreg << 1;
            if (cnt == 3'd4) begin
              cnt   <= 3'd0;
              state <= GAP;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          GAP: begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd2) begin
              if (col < LAST_COL) begin
                shreg <= glyph_code;
                col   <= col + 3'd1;
                cnt   <= 3'd0;
                state <= SHIFT;
              end else begin
                state     <= IDLE;
                line_done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glyph_scan_ctrl.sv
// Scoreboard bench for glyph_scan_ctrl. The stimulus drives pixel scans and
// pushes the expected pixel_on/line_done for each cycle. A monitor pops and
// compares these values on the falling edge.
module tb_glyph_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_tick;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [4:0] glyph_code;
  logic [2:0] rom_row;
  logic [4:0] glyph_sel;
  logic       pixel_on;
  logic       line_done;
  logic [2:0] hl_col;
  logic [1:0] hl_row;
  logic       hl_on;

  always #5 clk = ~clk;

  glyph_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .glyph_code(glyph_code),
`ifdef GLYPH_HILITE_EN
    .hl_col    (hl_col),
    .hl_row    (hl_row),
    .hl_on     (hl_on),
`endif
    .rom_row   (rom_row),
    .glyph_sel (glyph_sel),
    .pixel_on  (pixel_on),
    .line_done (line_done)
  );

  // ROM contents: 0 = all zeros, 1 = only row 2 of cell 1 lit, 2 = all ones, 3 = 10110 everywhere.
  int rom_mode = 0;

  function automatic logic [4:0] rom_f(input logic [2:0] r, input logic [4:0] s);
    case (rom_mode)
      1:       return ((r == 3'd2) && (s == 5'd1)) ? 5'b11111 : 5'b00000;
      2:       return 5'b11111;
      3:       return 5'b10110;
      default: return 5'b00000;
    endcase
  endfunction

  always_comb glyph_code = rom_f(rom_row, glyph_sel);

  typedef struct {
    logic pon;
    logic ld;
    int   x;
    int   y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ld_pend = 1'b0;
  logic hl_model = 1'b0;

  // Expected foreground for a pixel on a normally-started line.
  function automatic logic exp_pon(input int x, input int y, input logic vid, input logic aborted);
    int c, k, r, cr;
    logic [4:0] g;
    logic b;
    if (!vid || aborted) return 1'b0;
    if (y < 160 || y >= 192 || x < 200 || x > 231) return 1'b0;
    c  = (x - 200) / 8;
    k  = (x - 200) % 8;
    r  = (y - 160) % 8;
    cr = (y - 160) / 8;
    g  = rom_f(3'(r), 5'(cr * 8 + c));
    b  = (k < 5) ? g[4 - k] : 1'b0;
    if (hl_model && hl_on && (cr == int'(hl_row)) && (c == int'(hl_col))) b = ~b;
    return b;
  endfunction

  task automatic step(input int x, input int y, input logic tick, input logic vid,
                      input logic rst, input logic aborted);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    pix_tick = tick;
    video_on = vid;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    e.pon = exp_pon(x, y, vid, aborted);
    e.ld  = ld_pend;
    e.x   = x;
    e.y   = y;
    sb.push_back(e);
    ld_pend = tick && !rst && !aborted && (x == 231) && (y >= 160) && (y < 192);
  endtask

  task automatic scan_row(input int y, input int abort_x, input int vid_off_x, input int stall_x);
    logic aborted = 1'b0;
    for (int x = 195; x <= 240; x++) begin
      if (x == stall_x) begin
        for (int s = 0; s < 3; s++) step(x, y, 1'b0, 1'b1, 1'b0, aborted);
      end
      step(x, y, 1'b1, (x < vid_off_x), (x == abort_x), aborted);
      if (x == abort_x) aborted = 1'b1;
    end
  endtask

  // Monitor: compare each presented cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pixel_on !== e.pon) begin
        errors++;
        $display("FAIL pixel_on x=%0d y=%0d got %b expected %b", e.x, e.y, pixel_on, e.pon);
      end
      checks++;
      if (line_done !== e.ld) begin
        errors++;
        $display("FAIL line_done x=%0d y=%0d got %b expected %b", e.x, e.y, line_done, e.ld);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    pix_tick = 1'b0;
    video_on = 1'b1;
    pixel_x  = 10'd0;
    pixel_y  = 10'd0;
    hl_col   = 3'd0;
    hl_row   = 2'd0;
    hl_on    = 1'b0;
    repeat (2) @(posedge clk);

    // Reset holds with a qualifying tick present; the FSM stays idle afterwards.
    rom_mode = 2;
    step(199, 160, 1'b1, 1'b1, 1'b1, 1'b0);
    step(199, 160, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // A single lit glyph row, scanned over the top edge of the window.
    rom_mode = 1;
    for (int y = 158; y <= 169; y++) scan_row(y, -1, 9999, -1);

    // All-ones ROM: the row below the window stays dark; the rows inside are lit.
    rom_mode = 2;
    scan_row(192, -1, 9999, -1);
    scan_row(191, -1, 9999, -1);
    scan_row(160, -1, 9999, -1);

    // A pattern glyph with a three-cycle tick stall in mid-shift.
    rom_mode = 3;
    scan_row(170, -1, 9999, 202);
    // video_on drops mid-line; the sequencing continues and line_done still pulses.
    scan_row(171, -1, 210, -1);

    // Reset mid-glyph aborts the line; the next line draws normally.
    rom_mode = 2;
    scan_row(163, 210, 9999, -1);
    scan_row(164, -1, 9999, -1);

`ifdef GLYPH_HILITE_EN
    // Highlighted cell (col 1, row 0) over a blank ROM.
    rom_mode = 0;
    hl_model = 1'b1;
    hl_on    = 1'b1;
    hl_col   = 3'd1;
    hl_row   = 2'd0;
    for (int y = 158; y <= 169; y++) scan_row(y, -1, 9999, -1);
    hl_on    = 1'b0;
`endif

    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
